atpg_resp_checker: RTL and testbench
====================================

# atpg_resp_checker

Hardware response analyzer for ISCAS-85 ATPG runs: the capture end of the vector-application path. Once a stimulus source has applied a test vector to the circuit under test (CUT), the checker waits a settle interval, then samples the CUT primary outputs. It compares the sample against the golden response, counts mismatches, records the first failing vector index, and compacts all responses into a MISR signature. It sits between the CUT outputs and the test controller, and replaces file-based output dumping for on-chip or long-running fault campaigns.

## Interface
- OUT_W, 7: CUT primary-output width (c432: N223..N432).
- NUM_VEC, 10: vectors per run.
- SETTLE, 1: cycles from vector acceptance to output sample; legal range ≥1.
- IDX_W, $clog2(NUM_VEC): vector index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new run.
- vec_valid  in  1  stimulus side: vector is now driven on CUT inputs.
- vec_ready  out  1  checker can accept a vector.
- exp_out  in  OUT_W  golden response; valid with vec_valid.
- cut_out  in  OUT_W  CUT primary outputs.
- vec_idx  out  IDX_W  index of the next vector to accept.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  done && fail_count==0.
- fail_count  out  IDX_W+1  mismatching vectors this run.
- first_fail_idx  out  IDX_W  index of the first mismatch; 0 if none.
- signature  out  16  MISR signature.

## Operation
- FSM states: IDLE, WAIT_VEC, SETTLE, CAPTURE, DONE.
- IDLE/DONE + start → WAIT_VEC. Start clears vec_idx, fail_count, first_fail_idx and done, and loads signature with MISR_SEED.
- start in WAIT_VEC/SETTLE/CAPTURE is ignored.
- WAIT_VEC: vec_ready=1. On vec_valid && vec_ready, register exp_out and enter SETTLE with the settle counter set to SETTLE-1.
- SETTLE: decrement the counter; at 0 go to CAPTURE. vec_valid is ignored in this state.
- CAPTURE: sample cut_out, then in the same edge:
  - compare the sample against the registered expected value;
  - on mismatch, increment fail_count; if fail_count was 0, set first_fail_idx=vec_idx;
  - update the MISR;
  - increment vec_idx.
  - Next state is DONE if vec_idx==NUM_VEC-1, otherwise WAIT_VEC.
- MISR update: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0) ^ zero-extended cut_out. MISR_POLY=16'h1021, MISR_SEED=16'hFFFF.
- fail_count saturates at NUM_VEC by construction; there is no wrap.
- busy=1 in WAIT_VEC, SETTLE and CAPTURE.
- Reset mid-run: on the asynchronous reset, every output returns to its reset value and the FSM goes to IDLE. A partial run is discarded.

## Timing
- Reset values: vec_ready=0, busy=0, done=0, pass=0, vec_idx=0, fail_count=0, first_fail_idx=0, signature=16'h0000.
- Start pulse at edge n → vec_ready=1 from cycle n+1.
- Per vector: handshake edge h → CAPTURE in cycle h+SETTLE → results visible after edge h+SETTLE+1. Throughput is one vector per SETTLE+2 cycles.
- vec_ready drops the cycle after the handshake and returns when the FSM re-enters WAIT_VEC.
- The final capture edge sets done=1 and busy=0. pass is valid in the same cycle.
- Stimulus must hold CUT inputs stable from the handshake through CAPTURE.

## Configuration
- ATPG_RESP_MISR_EN defined: MISR logic is present and signature operates as described.
- ATPG_RESP_MISR_EN undefined: no MISR flops; signature is tied to 16'h0000. Compare and count behaviour is unchanged.

## Structure
- Package atpg_resp_pkg holds:
  - the state enum;
  - MISR_POLY, MISR_SEED and MISR_W=16.
- Sub-module resp_misr (parameters OUT_W, MISR_W; inputs clk, rst, load, shift, din; output sig) is instantiated only under ATPG_RESP_MISR_EN.

## Test plan
- Reset release, no start → all outputs at their reset values; vec_ready=0 for 20 cycles.
- NUM_VEC=10, cut_out==exp_out for every vector → done=1, pass=1, fail_count=0, first_fail_idx=0.
- Mismatches on vectors 3 and 7 (cut_out=7'h5A, exp_out=7'h5B) → fail_count=2, first_fail_idx=3, pass=0.
- NUM_VEC=1, cut_out=0 with MISR enabled → signature=16'hEFDF. With the macro undefined → signature=16'h0000.
- Assert rst during SETTLE of vector 5, then start a fresh all-match run → done=1, pass=1, fail_count=0.
- start pulse while busy, and vec_valid held during SETTLE → no restart and no extra acceptance; vec_idx advances by exactly 1 per vector.

Source files
------------

// File: rtl/atpg_resp_checker_pkg.sv
// atpg_resp_pkg: shared types and constants for the ATPG response checker.
// Holds the controller state encoding and the MISR polynomial/seed.
package atpg_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_VEC = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int              MISR_W    = 16;
   localparam logic [15:0]     MISR_POLY = 16'h1021;
   localparam logic [15:0]     MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/atpg_resp_checker_if.sv
// atpg_resp_checker_if: vector handshake between the stimulus source (master)
// and the response checker (slave), plus the CUT output / golden response.
interface atpg_resp_checker_if #(
   parameter int OUT_W = 7,
   parameter int IDX_W = 4
);
   logic             vec_valid;
   logic             vec_ready;
   logic [OUT_W-1:0] exp_out;
   logic [OUT_W-1:0] cut_out;
   logic [IDX_W-1:0] vec_idx;

   modport master (
      output vec_valid, exp_out, cut_out,
      input  vec_ready, vec_idx
   );

   modport slave (
      input  vec_valid, exp_out, cut_out,
      output vec_ready, vec_idx
   );
endinterface

// File: rtl/atpg_resp_checker_misr.sv
// resp_misr: 16-bit multiple-input signature register compacting CUT responses.
// load re-seeds the register at the start of a run; shift folds in one sample.
module resp_misr
   import atpg_resp_pkg::*;
#(
   parameter int OUT_W  = 7,
   parameter int MISR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [OUT_W-1:0]  din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] sig_d;

   // Next signature: shift left, fold the polynomial on MSB carry-out, xor in the sample.
   always_comb begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_W'(MISR_POLY) : '0)
            ^ MISR_W'(din);
   end

   // Signature register: cleared by reset, seeded on load, advanced on shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else if (load) begin
         sig_q <= MISR_W'(MISR_SEED);
      end else if (shift) begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/atpg_resp_checker.sv
// atpg_resp_checker: capture end of the ATPG vector-application path.
// Accepts a vector, waits SETTLE cycles, samples the CUT outputs, compares
// against the golden response, counts mismatches, records the first failing
// index and (when ATPG_RESP_MISR_EN is defined) compacts responses into a MISR.
// Without ATPG_RESP_MISR_EN the signature output is tied to zero.
module atpg_resp_checker
   import atpg_resp_pkg::*;
#(
   parameter int OUT_W   = 7,
   parameter int NUM_VEC = 10,
   parameter int SETTLE  = 1,
   parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   atpg_resp_checker_if.slave   vec_if,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [IDX_W:0]       fail_count,
   output logic [IDX_W-1:0]     first_fail_idx,
   output logic [MISR_W-1:0]    signature
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t             state_q;
   logic               vec_ready_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [IDX_W-1:0]   vec_idx_q;
   logic [IDX_W:0]     fail_q;
   logic [IDX_W-1:0]   ffi_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [OUT_W-1:0]   exp_q;

   logic               accept;
   logic               mismatch;
   logic               last_vec;

   assign accept   = (state_q == ST_WAIT_VEC) && vec_if.vec_valid && vec_ready_q;
   assign mismatch = (vec_if.cut_out != exp_q);
   assign last_vec = (vec_idx_q == IDX_W'(NUM_VEC - 1));

   // Golden response latch: data only, captured at the vector handshake.
   always_ff @(posedge clk) begin
      if (accept) begin
         exp_q <= vec_if.exp_out;
      end
   end

   // Run controller: handshake, settle countdown, capture/compare, registered status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vec_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         vec_idx_q   <= '0;
         fail_q      <= '0;
         ffi_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q     <= ST_WAIT_VEC;
                  vec_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  vec_idx_q   <= '0;
                  fail_q      <= '0;
                  ffi_q       <= '0;
               end
            end
            ST_WAIT_VEC: begin
               if (accept) begin
                  state_q     <= ST_SETTLE;
                  vec_ready_q <= 1'b0;
                  cnt_q       <= CNT_W'(SETTLE - 1);
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_CAPTURE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_CAPTURE: begin
               if (mismatch) begin
                  fail_q <= fail_q + (IDX_W + 1)'(1);
                  if (fail_q == '0) begin
                     ffi_q <= vec_idx_q;
                  end
               end
               vec_idx_q <= vec_idx_q + IDX_W'(1);
               if (last_vec) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (fail_q == '0) && !mismatch;
               end else begin
                  state_q     <= ST_WAIT_VEC;
                  vec_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ATPG_RESP_MISR_EN
   logic misr_load;
   logic misr_shift;

   assign misr_load  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign misr_shift = (state_q == ST_CAPTURE);

   resp_misr #(
      .OUT_W  (OUT_W),
      .MISR_W (MISR_W)
   ) u_misr (
      .clk   (clk),
      .rst   (rst),
      .load  (misr_load),
      .shift (misr_shift),
      .din   (vec_if.cut_out),
      .sig   (signature)
   );
`else
   assign signature = '0;
`endif

   assign vec_if.vec_ready = vec_ready_q;
   assign vec_if.vec_idx   = vec_idx_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_count       = fail_q;
   assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_atpg_resp_checker.sv
// tb_atpg_resp_checker: randomized runs of atpg_resp_checker against a
// run-level reference model (mismatch count, first failing index, signature),
// plus a single-vector instance for the signature reference value.
module tb_atpg_resp_checker;

   localparam int OUT_W   = 7;
   localparam int NUM_VEC = 10;
   localparam int SETTLE  = 2;
   localparam int IDX_W   = $clog2(NUM_VEC);

`ifdef ATPG_RESP_MISR_EN
   localparam bit MISR_ON = 1'b1;
`else
   localparam bit MISR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start1 = 1'b0;

   always #5 clk = ~clk;

   // Main instance: NUM_VEC=10, SETTLE=2
   atpg_resp_checker_if #(.OUT_W(OUT_W), .IDX_W(IDX_W)) vif ();
   logic              busy, done, pass;
   logic [IDX_W:0]    fcnt;
   logic [IDX_W-1:0]  ffi;
   logic [15:0]       sig;

   atpg_resp_checker #(
      .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .SETTLE(SETTLE), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .vec_if(vif),
      .busy(busy), .done(done), .pass(pass), .fail_count(fcnt),
      .first_fail_idx(ffi), .signature(sig)
   );

   // Single-vector instance: NUM_VEC=1, SETTLE=1
   atpg_resp_checker_if #(.OUT_W(OUT_W), .IDX_W(1)) vif1 ();
   logic        busy1, done1, pass1;
   logic [1:0]  fcnt1;
   logic [0:0]  ffi1;
   logic [15:0] sig1;

   atpg_resp_checker #(
      .OUT_W(OUT_W), .NUM_VEC(1), .SETTLE(1), .IDX_W(1)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .vec_if(vif1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_count(fcnt1),
      .first_fail_idx(ffi1), .signature(sig1)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference signature of a list of responses, computed from the MISR rule.
   function automatic logic [15:0] model_sig(input logic [6:0] c [NUM_VEC], input int n);
      logic [15:0] s;
      bit          fb;
      if (!MISR_ON) return 16'h0000;
      s = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         fb = s[15];
         s  = s << 1;
         if (fb) s = s ^ 16'h1021;
         s = s ^ {9'd0, c[i]};
      end
      return s;
   endfunction

   // Apply one vector to the main instance and follow it to its capture edge.
   task automatic apply_vec(input logic [6:0] e, input logic [6:0] c, input int idx,
                            input bit hold, input bit poke);
      int t = 0;
      @(negedge clk);
      while (!vif.vec_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", vif.vec_ready, 1);
      if (!vif.vec_ready) return;
      chk("idx_pre", vif.vec_idx, idx);
      vif.vec_valid = 1'b1;
      vif.exp_out   = e;
      vif.cut_out   = c;
      @(posedge clk); #1;
      chk("ready_drop", vif.vec_ready, 0);
      if (!hold) vif.vec_valid = 1'b0;
      for (int k = 1; k <= SETTLE; k++) begin
         @(negedge clk);
         if (poke && k == 1) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("idx_hold", vif.vec_idx, idx);
      chk("busy_mid", busy, 1);
      vif.vec_valid = 1'b0;
      @(posedge clk); #1;
      chk("idx_adv", vif.vec_idx, idx + 1);
      if (idx < NUM_VEC - 1) chk("ready_back", vif.vec_ready, 1);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("st_ready", vif.vec_ready, 1);
      chk("st_busy", busy, 1);
      chk("st_done", done, 0);
      chk("st_fcnt", fcnt, 0);
      chk("st_ffi", ffi, 0);
      chk("st_idx", vif.vec_idx, 0);
      chk("st_sig", sig, MISR_ON ? 32'hFFFF : 32'h0);
   endtask

   // One full run. mode 0: all match, 1: mismatches on 3 and 7, 2: random mismatches.
   task automatic run(input int mode);
      logic [6:0] e [NUM_VEC];
      logic [6:0] c [NUM_VEC];
      int nf = 0;
      int first = -1;
      for (int i = 0; i < NUM_VEC; i++) begin
         e[i] = 7'($urandom);
         c[i] = e[i];
         if (mode == 1 && (i == 3 || i == 7)) begin
            e[i] = 7'h5B;
            c[i] = 7'h5A;
         end
         if (mode == 2 && ($urandom % 3 == 0)) c[i] = e[i] ^ 7'(1 + $urandom % 127);
      end
      do_start();
      for (int i = 0; i < NUM_VEC; i++) begin
         apply_vec(e[i], c[i], i, 1'($urandom), 1'($urandom));
         if (c[i] != e[i]) begin
            if (first < 0) first = i;
            nf++;
         end
         chk("fcnt_run", fcnt, nf);
      end
      if (first < 0) first = 0;
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_pass", pass, (nf == 0) ? 1 : 0);
      chk("end_fcnt", fcnt, nf);
      chk("end_ffi", ffi, first);
      chk("end_sig", sig, model_sig(c, NUM_VEC));
      chk("end_ready", vif.vec_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done, 1);
      chk("pass_held", pass, (nf == 0) ? 1 : 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, vif.vec_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_idx"}, vif.vec_idx, 0);
      chk({tag, "_fcnt"}, fcnt, 0);
      chk({tag, "_ffi"}, ffi, 0);
      chk({tag, "_sig"}, sig, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vif.vec_valid  = 1'b0;
      vif.exp_out    = '0;
      vif.cut_out    = '0;
      vif1.vec_valid = 1'b0;
      vif1.exp_out   = '0;
      vif1.cut_out   = '0;

      // Reset release with no start: everything stays at reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready", vif.vec_ready, 0);
      end
      chk_reset_vals("rst");
      chk("rst1_sig", sig1, 0);
      chk("rst1_done", done1, 0);

      // Single-vector run with cut_out = 0
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      t = 0;
      while (!vif1.vec_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("v1_ready", vif1.vec_ready, 1);
      @(negedge clk);
      vif1.vec_valid = 1'b1;
      @(posedge clk); #1;
      vif1.vec_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("v1_done", done1, 1);
      chk("v1_busy", busy1, 0);
      chk("v1_pass", pass1, 1);
      chk("v1_fcnt", fcnt1, 0);
      chk("v1_sig", sig1, MISR_ON ? 32'hEFDF : 32'h0);

      // Full runs
      run(0);
      run(1);
      run(2);
      run(2);

      // Reset during SETTLE of vector 5
      do_start();
      for (int i = 0; i < 5; i++) apply_vec(7'($urandom), 7'($urandom), i, 1'b0, 1'b0);
      @(negedge clk);
      t = 0;
      while (!vif.vec_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("v5_ready", vif.vec_ready, 1);
      vif.vec_valid = 1'b1;
      vif.exp_out   = 7'h11;
      vif.cut_out   = 7'h22;
      @(posedge clk); #1;
      vif.vec_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      run(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
